// File: rtl/vr_tester_pkg.sv
// Shared types and constants for the valid/ready stream tester.
package vr_tester_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR16_TAPS = 16'hB400;
    localparam int          DUTY_W      = 5;

    // Galois right-shift: x^16 + x^14 + x^13 + x^11 + 1
    function automatic logic [15:0] lfsr16_step(input logic [15:0] q);
        return (q >> 1) ^ (q[0] ? LFSR16_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/vr_stream_tester_lfsr16.sv
// Free-running 16-bit Galois LFSR, loaded with its seed while in reset.
module lfsr16
    import vr_tester_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= seed;
        end else begin
            r_q <= lfsr16_step(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/vr_stream_tester.sv
// Traffic endpoint: throttled sequential source, throttled sink with in-order
// content check, and a no-progress timeout.
module vr_stream_tester
    import vr_tester_pkg::*;
#(
    parameter int          D_WIDTH  = 6,
    parameter int          N_WORDS  = 16,
    parameter int          SRC_DUTY = 8,
    parameter int          SNK_DUTY = 8,
    parameter logic [15:0] SRC_SEED = 16'hACE1,
    parameter logic [15:0] SNK_SEED = 16'h1D0F,
    parameter int          TIMEOUT  = 256
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               up_valid,
    input  logic               up_ready,
    output logic [D_WIDTH-1:0] up_data,
    input  logic               down_valid,
    output logic               down_ready,
    input  logic [D_WIDTH-1:0] down_data,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [7:0]         err_cnt,
    output logic [D_WIDTH-1:0] first_err
);

    localparam logic [15:0]       N_LAST  = 16'(N_WORDS);
    localparam logic [15:0]       TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [DUTY_W-1:0] SRC_THR = DUTY_W'(SRC_DUTY);
    localparam logic [DUTY_W-1:0] SNK_THR = DUTY_W'(SNK_DUTY);

    state_t             r_state;
    state_t             w_state_next;
    logic [15:0]        w_src_q;
    logic [15:0]        w_snk_q;
    logic [15:0]        r_tx_cnt;
    logic [15:0]        r_rx_cnt;
    logic [15:0]        r_idle_cnt;
    logic [15:0]        w_tx_after;
    logic [7:0]         r_err_cnt;
    logic [D_WIDTH-1:0] r_first_err;
    logic [D_WIDTH-1:0] r_up_data;
    logic               r_first_seen;
    logic               r_up_valid;
    logic               r_down_ready;
    logic               r_done;
    logic               r_pass;
    logic               r_timeout;
    logic               w_offer;
    logic               w_snk_rdy;
    logic               w_up_hs;
    logic               w_beat;
    logic               w_rx_done;
    logic               w_idle_to;
    logic               w_enter_run;
    logic               w_enter_done;
    logic               w_unused_lfsr;

    lfsr16 u_src_lfsr (.clk(clk), .rst(rst), .seed(SRC_SEED), .q(w_src_q));
    lfsr16 u_snk_lfsr (.clk(clk), .rst(rst), .seed(SNK_SEED), .q(w_snk_q));

    assign w_unused_lfsr = ^{w_src_q[15:4], w_snk_q[15:4]};
    assign w_offer       = {1'b0, w_src_q[3:0]} < SRC_THR;
    assign w_snk_rdy     = {1'b0, w_snk_q[3:0]} < SNK_THR;
    assign w_up_hs       = r_up_valid && up_ready;
    assign w_tx_after    = r_tx_cnt + {15'd0, w_up_hs};
    // Beats after the last expected word are not counted; the run is closing.
    assign w_beat        = (r_state == RUN) && down_valid && r_down_ready && (r_rx_cnt != N_LAST);
    assign w_rx_done     = (r_state == RUN) && (r_rx_cnt == N_LAST);
    assign w_idle_to     = (r_state == RUN) && !w_beat && (r_idle_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_rx_done || w_idle_to) w_state_next = DONE;
            DONE:    if (start) w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        w_enter_run  = 1'b0;
        w_enter_done = 1'b0;
        case (r_state)
            IDLE, DONE: w_enter_run = start;
            RUN: begin
                busy         = 1'b1;
                w_enter_done = w_rx_done || w_idle_to;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_cnt     <= '0;
            r_rx_cnt     <= '0;
            r_idle_cnt   <= '0;
            r_err_cnt    <= '0;
            r_first_err  <= '0;
            r_first_seen <= 1'b0;
            r_up_valid   <= 1'b0;
            r_up_data    <= '0;
            r_down_ready <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (w_enter_run) begin
            r_tx_cnt     <= '0;
            r_rx_cnt     <= '0;
            r_idle_cnt   <= '0;
            r_err_cnt    <= '0;
            r_first_err  <= '0;
            r_first_seen <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_up_valid   <= w_offer;
            r_up_data    <= '0;
            r_down_ready <= w_snk_rdy;
        end else if (r_state == RUN) begin
            if (w_up_hs) begin
                r_tx_cnt <= w_tx_after;
            end
            // A held offer only moves on handshake; the next offer is decided on that same edge.
            if (w_enter_done) begin
                r_up_valid <= 1'b0;
            end else if (!r_up_valid || w_up_hs) begin
                r_up_valid <= (w_tx_after < N_LAST) && w_offer;
                r_up_data  <= w_tx_after[D_WIDTH-1:0];
            end
            r_down_ready <= !w_enter_done && w_snk_rdy;
            if (w_beat) begin
                r_rx_cnt   <= r_rx_cnt + 16'd1;
                r_idle_cnt <= '0;
                if (down_data != r_rx_cnt[D_WIDTH-1:0]) begin
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                    if (!r_first_seen) begin
                        r_first_err  <= down_data;
                        r_first_seen <= 1'b1;
                    end
                end
            end else begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end
            if (w_enter_done) begin
                r_done    <= 1'b1;
                r_timeout <= !w_rx_done;
                r_pass    <= w_rx_done && (r_err_cnt == 8'd0);
            end
        end
    end

    assign up_valid   = r_up_valid;
    assign up_data    = r_up_data;
    assign down_ready = r_down_ready;
    assign done       = r_done;
    assign pass       = r_pass;
    assign timeout    = r_timeout;
    assign err_cnt    = r_err_cnt;
    assign first_err  = r_first_err;

endmodule
